// File: rtl/sram_dp_pkg.sv
// Shared types and helpers for the simple-dual-port SRAM with init sequencer.
// SRAM_DP_OUT_REG_EN selects the two-cycle read latency variant.
package sram_dp_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

`ifdef SRAM_DP_OUT_REG_EN
  localparam int RD_LATENCY = 2;
`else
  localparam int RD_LATENCY = 1;
`endif

  // Widest word / lane count lane_merge can handle; callers zero-extend into it.
  localparam int MAX_W     = 1024;
  localparam int MAX_LANES = 1024;
  localparam int IDX_W     = $clog2(MAX_W);

  function automatic logic [MAX_W-1:0] lane_merge(
    input logic [MAX_W-1:0]     old_w,
    input logic [MAX_W-1:0]     new_w,
    input logic [MAX_LANES-1:0] be,
    input int                   bw
  );
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_W; i++) begin
      if (be[IDX_W'(i / bw)]) r[IDX_W'(i)] = new_w[IDX_W'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_dp_mem_array.sv
// Storage array: byte-lane write, combinational read, no reset on contents.
// Out-of-range indices are ignored on write and read back as zero.
module sram_dp_mem_array
  import sram_dp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_SIZE   = 16
) (
  input  logic                             clk,
  input  logic                             i_we,
  input  logic [ADDR_WIDTH-1:0]            i_waddr,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_wbe,
  input  logic [ADDR_WIDTH-1:0]            i_raddr,
  output logic [DATA_WIDTH-1:0]            o_rdata
);

  localparam logic [ADDR_WIDTH:0] SIZE_C = (ADDR_WIDTH+1)'(RAM_SIZE);

  logic [DATA_WIDTH-1:0] r_mem [RAM_SIZE];
  logic                  w_wr_inr;
  logic                  w_rd_inr;

  assign w_wr_inr = {1'b0, i_waddr} < SIZE_C;
  assign w_rd_inr = {1'b0, i_raddr} < SIZE_C;

  always_ff @(posedge clk) begin
    if (i_we && w_wr_inr)
      r_mem[i_waddr] <= DATA_WIDTH'(lane_merge(MAX_W'(r_mem[i_waddr]), MAX_W'(i_wdata),
                                               MAX_LANES'(i_wbe), BYTE_WIDTH));
  end

  assign o_rdata = w_rd_inr ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/sram_dual_port_init.sv
// Simple-dual-port SRAM with write-first bypass, range check and init sequencer.
// Define SRAM_DP_OUT_REG_EN for an extra output register stage (read latency 2).
module sram_dual_port_init
  import sram_dp_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    BYTE_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    RAM_SIZE   = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_init_req,
  input  logic                             i_wr_en,
  input  logic [ADDR_WIDTH-1:0]            i_wr_addr,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_wr_be,
  input  logic                             i_rd_en,
  input  logic [ADDR_WIDTH-1:0]            i_rd_addr,
  output logic [DATA_WIDTH-1:0]            o_rd_data,
  output logic                             o_rd_valid,
  output logic                             o_collision,
  output logic                             o_addr_err,
  output logic                             o_init_done
);

  localparam int                  NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0] SIZE_C    = (ADDR_WIDTH+1)'(RAM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(RAM_SIZE - 1);

  state_t                  r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_init_ptr;

  logic                    w_arr_we;
  logic [ADDR_WIDTH-1:0]   w_arr_waddr;
  logic [DATA_WIDTH-1:0]   w_arr_wdata;
  logic [NUM_LANES-1:0]    w_arr_wbe;
  logic [DATA_WIDTH-1:0]   w_rd_old;

  logic                    w_ready;
  logic                    w_acc;
  logic                    w_init_start;
  logic                    w_wr_inr, w_rd_inr;
  logic                    w_rd_acc, w_coll, w_err;
  logic [DATA_WIDTH-1:0]   w_byp;

  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_rd_valid, r_coll, r_addr_err;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (r_init_ptr == LAST_C) w_state_nxt = ST_READY;
      ST_READY: if (i_init_req)           w_state_nxt = ST_INIT;
      default:                            w_state_nxt = ST_INIT;
    endcase
  end

  // While initialising the array port is owned by the sequencer.
  always_comb begin
    w_ready     = 1'b0;
    w_arr_we    = 1'b1;
    w_arr_waddr = r_init_ptr;
    w_arr_wdata = INIT_VAL;
    w_arr_wbe   = '1;
    if (r_state == ST_READY) begin
      w_ready     = 1'b1;
      w_arr_we    = i_wr_en & w_wr_inr & ~i_init_req;
      w_arr_waddr = i_wr_addr;
      w_arr_wdata = i_wr_data;
      w_arr_wbe   = i_wr_be;
    end
  end

  assign o_init_done = w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        r_init_ptr <= '0;
    else if (r_state == ST_INIT && r_init_ptr != LAST_C) r_init_ptr <= r_init_ptr + 1'b1;
    else                                               r_init_ptr <= '0;
  end

  // ---------------- array ----------------
  sram_dp_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_SIZE   (RAM_SIZE)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_waddr (w_arr_waddr),
    .i_wdata (w_arr_wdata),
    .i_wbe   (w_arr_wbe),
    .i_raddr (i_rd_addr),
    .o_rdata (w_rd_old)
  );

  // ---------------- access decode ----------------
  assign w_init_start = w_ready & i_init_req;
  assign w_acc        = w_ready & ~i_init_req;
  assign w_wr_inr     = {1'b0, i_wr_addr} < SIZE_C;
  assign w_rd_inr     = {1'b0, i_rd_addr} < SIZE_C;
  assign w_rd_acc     = w_acc & i_rd_en;
  assign w_coll       = w_rd_acc & i_wr_en & w_rd_inr & (i_rd_addr == i_wr_addr);
  assign w_err        = w_acc & ((i_rd_en & ~w_rd_inr) | (i_wr_en & ~w_wr_inr));
  assign w_byp        = DATA_WIDTH'(lane_merge(MAX_W'(w_rd_old), MAX_W'(i_wr_data),
                                               MAX_LANES'(i_wr_be), BYTE_WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_coll     <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      r_coll     <= w_coll;
      r_addr_err <= w_err;
      if (w_rd_acc) r_rd_data <= !w_rd_inr ? '0 : (w_coll ? w_byp : w_rd_old);
    end
  end

`ifdef SRAM_DP_OUT_REG_EN
  logic [DATA_WIDTH-1:0] r_rd_data2;
  logic                  r_rd_valid2, r_coll2, r_addr_err2;

  // A re-init request drops whatever read is still in this stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data2  <= '0;
      r_rd_valid2 <= 1'b0;
      r_coll2     <= 1'b0;
      r_addr_err2 <= 1'b0;
    end else if (w_init_start) begin
      r_rd_valid2 <= 1'b0;
      r_coll2     <= 1'b0;
      r_addr_err2 <= 1'b0;
    end else begin
      r_rd_data2  <= r_rd_data;
      r_rd_valid2 <= r_rd_valid;
      r_coll2     <= r_coll;
      r_addr_err2 <= r_addr_err;
    end
  end

  assign o_rd_data   = r_rd_data2;
  assign o_rd_valid  = r_rd_valid2;
  assign o_collision = r_coll2;
  assign o_addr_err  = r_addr_err2;
`else
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_collision = r_coll;
  assign o_addr_err  = r_addr_err;
`endif

endmodule

// File: tb/tb_sram_dual_port_init.sv
// Bench for sram_dual_port_init: 32-bit words, 12-entry array in a 4-bit address space.
module tb_sram_dual_port_init;
  import sram_dp_pkg::*;

  localparam int DW = 32, BW = 8, AW = 4, RS = 12, NL = DW / BW;
  localparam logic [DW-1:0] IV = '0;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          init_req = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [NL-1:0] wr_be = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, collision, addr_err, init_done;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  sram_dual_port_init #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW), .RAM_SIZE(RS), .INIT_VAL(IV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_init_req(init_req),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_collision(collision),
    .o_addr_err(addr_err), .o_init_done(init_done)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, DW'(act), DW'(exp));
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [DW-1:0] data;
    logic          vld;
    logic          col;
    logic          err;
  } res_t;

  logic [DW-1:0] mm [RS];
  bit            m_ready;
  int            m_left;
  res_t          s1, s2;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [NL-1:0] be);
    for (int k = 0; k < NL; k++) if (be[k]) o[k*BW +: BW] = n[k*BW +: BW];
    return o;
  endfunction

  task automatic m_reset();
    m_ready = 1'b0;
    m_left  = RS;
    s1      = '0;
    s2      = '0;
    foreach (mm[i]) mm[i] = IV;
  endtask

  task automatic m_edge();
    res_t n1;
    bit   flush;
    flush   = 1'b0;
    n1      = '0;
    n1.data = s1.data;
    if (!m_ready) begin
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end else if (init_req) begin
      m_ready = 1'b0;
      m_left  = RS;
      foreach (mm[i]) mm[i] = IV;
      flush = 1'b1;
    end else begin
      if (rd_en) begin
        n1.vld = 1'b1;
        if (int'(rd_addr) >= RS) begin
          n1.data = '0;
          n1.err  = 1'b1;
        end else begin
          n1.data = mm[rd_addr];
          if (wr_en && wr_addr == rd_addr) begin
            n1.data = merge(n1.data, wr_data, wr_be);
            n1.col  = 1'b1;
          end
        end
      end
      if (wr_en) begin
        if (int'(wr_addr) >= RS) n1.err = 1'b1;
        else mm[wr_addr] = merge(mm[wr_addr], wr_data, wr_be);
      end
    end
    if (flush) begin
      s2.vld = 1'b0; s2.col = 1'b0; s2.err = 1'b0;
    end else begin
      s2 = s1;
    end
    s1 = n1;
  endtask

  initial begin
    res_t ex;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_edge();
      #1;
      ex = (RD_LATENCY == 2) ? s2 : s1;
      chk("m_rd_data", rd_data, ex.data);
      chk1("m_rd_valid", rd_valid, ex.vld);
      chk1("m_collision", collision, ex.col);
      chk1("m_addr_err", addr_err, ex.err);
      chk1("m_init_done", init_done, m_ready);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    init_req = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 200) begin
      step();
      n++;
      chk1("rdv_during_init", rd_valid, 1'b0);
    end
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [NL-1:0] be;
    bit            re;
    logic [AW-1:0] ra;
    bit            ev;
    logic [DW-1:0] ed;
    bit            ec;
    bit            ee;
  } tv_t;

  tv_t tv [16];

  initial begin
    int n;
    tv[0]  = '{1'b1, 4'd3,  32'h0000_00A5, 4'hF, 1'b0, 4'd0,  1'b0, 32'h0,         1'b0, 1'b0};
    tv[1]  = '{1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd3,  1'b1, 32'h0000_00A5, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 4'd7,  32'h1122_3344, 4'hF, 1'b0, 4'd0,  1'b0, 32'h0,         1'b0, 1'b0};
    tv[3]  = '{1'b1, 4'd7,  32'hAABB_CCDD, 4'h5, 1'b0, 4'd0,  1'b0, 32'h0,         1'b0, 1'b0};
    tv[4]  = '{1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd7,  1'b1, 32'h11BB_33DD, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 4'd5,  32'h1122_3344, 4'hF, 1'b0, 4'd0,  1'b0, 32'h0,         1'b0, 1'b0};
    tv[6]  = '{1'b1, 4'd5,  32'hAABB_CCDD, 4'hC, 1'b1, 4'd5,  1'b1, 32'hAABB_3344, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd5,  1'b1, 32'hAABB_3344, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 4'd13, 32'hDEAD_BEEF, 4'hF, 1'b0, 4'd0,  1'b0, 32'h0,         1'b0, 1'b1};
    tv[9]  = '{1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd14, 1'b1, 32'h0,         1'b0, 1'b1};
    tv[10] = '{1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd11, 1'b1, 32'h0,         1'b0, 1'b0};
    tv[11] = '{1'b1, 4'd11, 32'hCAFE_F00D, 4'hF, 1'b0, 4'd0,  1'b0, 32'h0,         1'b0, 1'b0};
    tv[12] = '{1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd11, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0};
    tv[13] = '{1'b1, 4'd12, 32'h1234_5678, 4'hF, 1'b1, 4'd12, 1'b1, 32'h0,         1'b0, 1'b1};
    tv[14] = '{1'b1, 4'd4,  32'h0000_FFFF, 4'h3, 1'b1, 4'd9,  1'b1, 32'h0,         1'b0, 1'b0};
    tv[15] = '{1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd4,  1'b1, 32'h0000_FFFF, 1'b0, 1'b0};

    // Reset, then the init sequencer must take exactly RS cycles.
    rst_n = 1'b0;
    repeat (3) step();
    chk1("rst_init_done", init_done, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    rst_n = 1'b1;
    wait_init(n);
    chk("init_cycles", DW'(n), DW'(RS));

    // Back-to-back reads of every cleared word.
    for (int a = 0; a < RS; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      step();
    end
    idle();
    repeat (2) step();

    // Directed vectors, each checked RD_LATENCY cycles after issue.
    for (int i = 0; i < 16; i++) begin
      wr_en = tv[i].we; wr_addr = tv[i].wa; wr_data = tv[i].wd; wr_be = tv[i].be;
      rd_en = tv[i].re; rd_addr = tv[i].ra;
      step();
      idle();
      repeat (RD_LATENCY - 1) step();
      if (tv[i].ev) chk($sformatf("tv%0d_data", i), rd_data, tv[i].ed);
      chk1($sformatf("tv%0d_valid", i), rd_valid, tv[i].ev);
      chk1($sformatf("tv%0d_coll", i), collision, tv[i].ec);
      chk1($sformatf("tv%0d_err", i), addr_err, tv[i].ee);
    end

    // Random traffic against the model, including occasional re-init.
    for (int c = 0; c < 400; c++) begin
      init_req = ($urandom_range(0, 39) == 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom_range(0, 15));
      wr_data  = $urandom;
      wr_be    = NL'($urandom);
      rd_en    = 1'($urandom_range(0, 1));
      rd_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 15));
      step();
    end
    idle();
    wait_init(n);
    repeat (2) step();

    // Async reset while a read result is on the outputs.
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h5A5A_0F0F; wr_be = '1;
    step();
    idle();
    rd_en = 1'b1; rd_addr = 4'd2;
    step();
    idle();
    repeat (RD_LATENCY - 1) step();
    chk1("pre_rst_valid", rd_valid, 1'b1);
    chk("pre_rst_data", rd_data, 32'h5A5A_0F0F);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", rd_data, '0);
    chk1("async_rst_valid", rd_valid, 1'b0);
    chk1("async_rst_done", init_done, 1'b0);
    step();
    rst_n = 1'b1;

    // Reset again at init cycle 7; init must restart from word 0.
    repeat (7) step();
    #2 rst_n = 1'b0;
    #1;
    chk1("midinit_rst_done", init_done, 1'b0);
    chk("midinit_rst_data", rd_data, '0);
    step();
    rst_n = 1'b1;
    wait_init(n);
    chk("reinit_after_rst_cycles", DW'(n), DW'(RS));

    // init_req in READY: same-cycle read ignored, reads during re-init give no valid.
    rd_en = 1'b1; rd_addr = 4'd3; init_req = 1'b1;
    step();
    init_req = 1'b0;
    chk1("ireq_done_fall", init_done, 1'b0);
    chk1("ireq_read_dropped", rd_valid, 1'b0);
    wait_init(n);
    chk("ireq_init_cycles", DW'(n), DW'(RS));
    idle();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
